// File: rtl/barrel_regfile_pkg.sv
// Shared definitions for the barrel register file and the pipeline stages
// that talk to it (writeback, decode): register-address width, thread-ID
// width helper and the clear/run state encoding.
package barrel_regfile_pkg;

  localparam int REG_ADDR_W          = 5;
  localparam int NUM_ARCH_REGS       = 32;
  localparam int DEFAULT_NUM_THREADS = 8;

  // Thread-ID width; a single-thread build still gets a 1-bit field.
  function automatic int tid_width(input int num_threads);
    return (num_threads > 1) ? $clog2(num_threads) : 1;
  endfunction

  localparam int DEFAULT_BITS_THREADS = tid_width(DEFAULT_NUM_THREADS);

  typedef logic [DEFAULT_BITS_THREADS-1:0] tid_t;
  typedef logic [REG_ADDR_W-1:0]           reg_addr_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/barrel_regfile_if.sv
// Writeback/decode bundle for the barrel register file.
// master: pipeline side (writeback + decode); slave: the register file.
interface barrel_regfile_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_THREADS = 8
);
  import barrel_regfile_pkg::*;

  localparam int BITS_THREADS = tid_width(NUM_THREADS);

  // writeback port
  logic                    reg_write_w;
  logic [REG_ADDR_W-1:0]   rd_w;
  logic [BITS_THREADS-1:0] tid_w;
  logic [DATA_WIDTH-1:0]   result_w;
  // decode read ports
  logic [BITS_THREADS-1:0] tid_d;
  logic [REG_ADDR_W-1:0]   rs1_d;
  logic [REG_ADDR_W-1:0]   rs2_d;
  logic [DATA_WIDTH-1:0]   rd1_d;
  logic [DATA_WIDTH-1:0]   rd2_d;
  logic                    ready;

  modport master (
    output reg_write_w, rd_w, tid_w, result_w, tid_d, rs1_d, rs2_d,
    input  rd1_d, rd2_d, ready
  );

  modport slave (
    input  reg_write_w, rd_w, tid_w, result_w, tid_d, rs1_d, rs2_d,
    output rd1_d, rd2_d, ready
  );

endinterface

// File: rtl/barrel_regfile_ram.sv
// Flat storage for all threads: one write port, two registered read ports.
// Plain read-first block RAM; x0 handling and forwarding live in the top.
module barrel_regfile_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr1_i,
  input  logic [ADDR_W-1:0]     raddr2_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [DATA_WIDTH-1:0] rdata2_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Single write port.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered reads; a same-edge write is not seen (read-first).
  always_ff @(posedge clk) begin
    rdata1_o <= mem_q[raddr1_i];
    rdata2_o <= mem_q[raddr2_i];
  end

endmodule

// File: rtl/barrel_regfile.sv
// Per-thread architectural register file for the barrel core.
// After reset a sequential clear zeroes every entry; ready stays low until
// it completes. x0 of every thread reads as zero.
// Optional macro REGFILE_BYPASS_EN: same-cycle matching write is forwarded
// to the read output (write-first); otherwise reads are read-first.
module barrel_regfile
  import barrel_regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_THREADS = 8
) (
  input logic             clk,
  input logic             rst,
  barrel_regfile_if.slave bus
);

  localparam int BITS_THREADS = tid_width(NUM_THREADS);
  localparam int ENTRY_W      = BITS_THREADS + REG_ADDR_W;
  localparam int NUM_ENTRIES  = NUM_THREADS * NUM_ARCH_REGS;
  localparam logic [ENTRY_W-1:0] LAST_ENTRY = ENTRY_W'(NUM_ENTRIES - 1);

  rf_state_e          state_q;
  logic [ENTRY_W-1:0] clr_cnt_q;
  logic               ready_q;
  logic               run;

  assign run = (state_q == ST_RUN);

  // Clear sequencer: walk every entry once, then stay in RUN until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_ENTRY) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
        default: begin
          state_q   <= ST_CLEAR;
          clr_cnt_q <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  // Write mux: the clear sequence owns the port until RUN; writes to x0
  // are dropped so x0 storage stays zero as well.
  logic                  wb_we;
  logic                  ram_we;
  logic [ENTRY_W-1:0]    ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  assign wb_we     = run && !rst && bus.reg_write_w && (bus.rd_w != '0);
  assign ram_we    = !run || wb_we;
  assign ram_waddr = run ? {bus.tid_w, bus.rd_w} : clr_cnt_q;
  assign ram_wdata = run ? bus.result_w : '0;

  logic [REG_ADDR_W-1:0] rs_sel    [2];
  logic [DATA_WIDTH-1:0] ram_rdata [2];
  logic [DATA_WIDTH-1:0] rd_out    [2];

  assign rs_sel[0] = bus.rs1_d;
  assign rs_sel[1] = bus.rs2_d;

  barrel_regfile_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (NUM_ENTRIES),
    .ADDR_W     (ENTRY_W)
  ) u_ram (
    .clk      (clk),
    .we_i     (ram_we),
    .waddr_i  (ram_waddr),
    .wdata_i  (ram_wdata),
    .raddr1_i ({bus.tid_d, rs_sel[0]}),
    .raddr2_i ({bus.tid_d, rs_sel[1]}),
    .rdata1_o (ram_rdata[0]),
    .rdata2_o (ram_rdata[1])
  );

`ifdef REGFILE_BYPASS_EN
  logic [DATA_WIDTH-1:0] byp_data_q;

  // Capture the write data alongside the read address for forwarding.
  always_ff @(posedge clk) begin
    byp_data_q <= bus.result_w;
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic zero_q;
`ifdef REGFILE_BYPASS_EN
      logic hit;
      logic byp_q;

      // wb_we already excludes x0 and non-RUN states.
      assign hit = wb_we && (bus.tid_w == bus.tid_d) && (bus.rd_w == rs_sel[gi]);

      // Track, per read, whether it must return zero or the forwarded write.
      always_ff @(posedge clk) begin
        if (rst) begin
          zero_q <= 1'b1;
          byp_q  <= 1'b0;
        end else begin
          zero_q <= !run || (rs_sel[gi] == '0);
          byp_q  <= hit;
        end
      end

      assign rd_out[gi] = zero_q ? '0 : (byp_q ? byp_data_q : ram_rdata[gi]);
`else
      // Track, per read, whether it must return zero (clear phase or x0).
      always_ff @(posedge clk) begin
        if (rst) zero_q <= 1'b1;
        else     zero_q <= !run || (rs_sel[gi] == '0);
      end

      assign rd_out[gi] = zero_q ? '0 : ram_rdata[gi];
`endif
    end
  endgenerate

  assign bus.rd1_d = rd_out[0];
  assign bus.rd2_d = rd_out[1];
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_barrel_regfile.sv
// Scoreboard bench for barrel_regfile: stimulus queues expected read data,
// a monitor pops and compares one cycle after each read is issued and also
// checks ready every cycle against the expected clear timing.
module tb_barrel_regfile;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  barrel_regfile_if #(.DATA_WIDTH(32), .NUM_THREADS(8)) bus ();

  barrel_regfile #(.DATA_WIDTH(32), .NUM_THREADS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          id;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t q[$];
  int   rd_id     = 0;
  bit   rd_req    = 1'b0;
  bit   pend      = 1'b0;
  bit   chk_en    = 1'b0;
  bit   exp_ready = 1'b0;
  bit   done      = 1'b0;
  int   n_chk     = 0;
  int   n_fail    = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus: optional writeback write and optional read.
  task automatic op(input bit we, input int tw, input int rw, input logic [31:0] val,
                    input bit re, input int td, input int a1, input int a2,
                    input logic [31:0] e1, input logic [31:0] e2);
    bus.reg_write_w = we;
    bus.tid_w       = 3'(tw);
    bus.rd_w        = 5'(rw);
    bus.result_w    = val;
    bus.tid_d       = 3'(td);
    bus.rs1_d       = 5'(a1);
    bus.rs2_d       = 5'(a2);
    rd_req          = re;
    if (re) begin
      q.push_back('{rd_id, e1, e2});
      rd_id++;
    end
    tick();
  endtask

  task automatic wr(input int t, input int r, input logic [31:0] v);
    op(1'b1, t, r, v, 1'b0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic rd(input int t, input int a1, input int a2,
                    input logic [31:0] e1, input logic [31:0] e2);
    op(1'b0, 0, 0, 32'h0, 1'b1, t, a1, a2, e1, e2);
  endtask

  task automatic idle();
    op(1'b0, 0, 0, 32'h0, 1'b0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  // Clear sequence with reads every cycle expected to return zero.
  task automatic clear_phase(input int cycles, input bit finishes);
    for (int i = 1; i <= cycles; i++) begin
      op(1'b0, 0, 0, 32'h0, 1'b1, i % 8, i % 32, (i + 3) % 32, 32'h0, 32'h0);
      if (finishes && i == cycles) exp_ready = 1'b1;
    end
  endtask

  always @(posedge clk) pend <= rd_req;

  // Monitor: ready every cycle, read data whenever a read was issued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        n_chk++;
        if (bus.ready !== exp_ready) begin
          n_fail++;
          $display("FAIL ready @%0t: got %b expected %b", $time, bus.ready, exp_ready);
        end
      end
      if (pend) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard: read output with no expectation queued");
        end else begin
          e = q.pop_front();
          if (bus.rd1_d !== e.e1) begin
            n_fail++;
            $display("FAIL read%0d port1: got %h expected %h", e.id, bus.rd1_d, e.e1);
          end
          n_chk++;
          if (bus.rd2_d !== e.e2) begin
            n_fail++;
            $display("FAIL read%0d port2: got %h expected %h", e.id, bus.rd2_d, e.e2);
          end
        end
      end
      if (done) begin
        n_chk++;
        if (q.size() != 0) begin
          n_fail++;
          $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    logic [31:0] old_val;
    logic [31:0] new_val;
    rst = 1'b1;
    bus.reg_write_w = 1'b0;
    bus.tid_w = '0; bus.rd_w = '0; bus.result_w = '0;
    bus.tid_d = '0; bus.rs1_d = '0; bus.rs2_d = '0;
    tick();
    chk_en    = 1'b1;
    exp_ready = 1'b0;
    rst       = 1'b0;

    // Full clear; a write to tid 3 x5 mid-clear must be dropped.
    for (int i = 1; i <= 256; i++) begin
      op(i == 10, 3, 5, 32'hDEAD, 1'b1, 3, 5, 7, 32'h0, 32'h0);
      if (i == 256) exp_ready = 1'b1;
    end
    rd(3, 5, 5, 32'h0, 32'h0);

    // Basic write/read and thread isolation.
    wr(2, 7, 32'h12345678);
    rd(2, 7, 7, 32'h12345678, 32'h12345678);
    rd(1, 7, 7, 32'h0, 32'h0);

    // x0 never holds data.
    wr(0, 0, 32'hFFFFFFFF);
    rd(0, 0, 0, 32'h0, 32'h0);
    rd(7, 0, 0, 32'h0, 32'h0);

    // Same-cycle write/read of the same entry.
    old_val = 32'h1;
    new_val = 32'hA5A5A5A5;
    wr(4, 10, old_val);
`ifdef REGFILE_BYPASS_EN
    op(1'b1, 4, 10, new_val, 1'b1, 4, 10, 10, new_val, new_val);
`else
    op(1'b1, 4, 10, new_val, 1'b1, 4, 10, 10, old_val, old_val);
`endif
    rd(4, 10, 10, new_val, new_val);
    // Same-cycle write to another thread does not disturb the read.
    op(1'b1, 5, 10, 32'h77, 1'b1, 4, 10, 0, new_val, 32'h0);
    // Same-cycle write to x0 of the read thread: no forwarding.
    op(1'b1, 4, 0, 32'hBAD, 1'b1, 4, 0, 10, 32'h0, new_val);

    // Fill every thread's x1..x31 with {tid,reg}, then read all back.
    for (int t = 0; t < 8; t++)
      for (int r = 1; r < 32; r++)
        wr(t, r, 32'((t << 5) | r));
    for (int t = 0; t < 8; t++)
      for (int r = 1; r < 32; r++)
        rd(t, r, (r % 31) + 1, 32'((t << 5) | r), 32'((t << 5) | ((r % 31) + 1)));

    // Reset in RUN, then reset again at clear cycle 100.
    rst = 1'b1;
    idle();
    exp_ready = 1'b0;
    rst = 1'b0;
    clear_phase(100, 1'b0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    clear_phase(256, 1'b1);
    rd(2, 7, 31, 32'h0, 32'h0);
    rd(7, 31, 1, 32'h0, 32'h0);
    rd(5, 3, 10, 32'h0, 32'h0);
    idle();
    idle();
    done = 1'b1;
  end

endmodule

// File: doc/barrel_regfile.md
Name: barrel_regfile

Overview:
- Per-thread architectural register file for the barrel RISC-V core.
- Consumer end of the writeback interface: accepts reg_write_w/rd_w/tid_w/result_w from the writeback stage.
- Serves two synchronous read ports to decode, indexed by thread ID.
- After reset, runs a sequential clear of all entries and holds ready low until the clear completes.

Parameters:
- DATA_WIDTH, 32, register width.
- NUM_THREADS, 8, hardware threads; one 32-entry bank each; power of two.
- BITS_THREADS, $clog2(NUM_THREADS), thread-ID width (localparam).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- reg_write_w  in  1  write enable from writeback.
- rd_w  in  5  destination register.
- tid_w  in  BITS_THREADS  writing thread.
- result_w  in  DATA_WIDTH  write data.
- tid_d  in  BITS_THREADS  reading thread.
- rs1_d  in  5  read address, port 1.
- rs2_d  in  5  read address, port 2.
- rd1_d  out  DATA_WIDTH  read data, port 1.
- rd2_d  out  DATA_WIDTH  read data, port 2.
- ready  out  1  high once the clear sequence is done.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Storage: NUM_THREADS*32 entries, addressed as {tid, reg}. x0 of every thread always reads 0.
- Reset:
  - FSM enters CLEAR and clr_cnt=0.
  - ready=0, rd1_d=0, rd2_d=0.
- FSM state CLEAR:
  - Each cycle writes 0 to entry clr_cnt, then clr_cnt++.
  - After entry NUM_THREADS*32-1 is written (256 cycles at default), go to RUN. ready goes high the cycle after the last clear write.
  - Writeback writes are ignored.
  - Read outputs are forced to 0.
- FSM state RUN:
  - Stays in RUN until rst.
  - Writes: if reg_write_w=1 and rd_w!=0, entry {tid_w,rd_w} ← result_w at the clk edge. Writes with rd_w=0 are dropped.
  - Reads: registered, latency 1. Addresses sampled at edge N; rd1_d/rd2_d valid after edge N, held until the next edge.
  - A read of rs=0 returns 0 regardless of thread.
- Reset mid-clear: clr_cnt restarts at 0 and the full clear repeats.
- Reset in RUN: returns to CLEAR; all contents are cleared again.
- Same-cycle write and read of the same {tid,reg}: result depends on REGFILE_BYPASS_EN (below).
- Same-cycle write to a different thread or register: no interaction.
- Both read ports may address the same entry; each returns identical data.
- tid_d and tid_w are independent. In a barrel pipeline they normally differ; correctness must not depend on that.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a same-cycle matching write forwards result_w to the read output (write-first). Matching means reg_write_w=1, rd_w!=0, {tid_w,rd_w}=={tid_d,rsX_d}, state RUN.
- Not defined: read-first; the read returns the pre-write value, and the new value is visible from the next read.
- In both cases ready, the clear FSM and the x0 rules are unchanged.

Decomposition:
- Shared package:
  - REG_ADDR_W=5.
  - NUM_ARCH_REGS=32.
  - Thread-ID width function/typedef reused by the writeback and decode stages.
  - FSM state encoding (CLEAR, RUN).
- One sub-module, regfile_ram:
  - Flat array, one write port, two registered read ports, no x0 or bypass logic.
- barrel_regfile holds the FSM, clear counter, x0 masking, bypass and the write mux (clear vs writeback).

Test Plan:
- Reset, then hold rst=0: ready=0 for 256 cycles, then 1. All rd1_d/rd2_d=0 during the clear. A write to tid 3, x5 of 0xDEAD during the clear is dropped, so a later read returns 0.
- After ready: write tid 2, x7=0x12345678; next cycle read tid 2, rs1=7 → rd1_d=0x12345678 one cycle later. Read tid 1, rs1=7 → 0 (thread isolation).
- Write tid 0, x0=0xFFFFFFFF, then read x0 on both ports for tids 0 and 7 → 0.
- Same-cycle write tid 4, x10=0xA5A5A5A5 and read tid 4, rs1=rs2=10, old value 0x1:
  - with REGFILE_BYPASS_EN, both ports → 0xA5A5A5A5;
  - without it, both ports → 0x1, and the next-cycle read → 0xA5A5A5A5.
- Fill x1..x31 of all 8 threads with value {tid,reg}, then read back all 248 entries on both ports; every read matches.
- Assert rst at clear cycle 100: ready stays 0 for a further 256 cycles. Assert rst in RUN after writes: previously written registers read 0 after ready returns.
